// File: rtl/vram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_pkg
// Description : Shared constants and state encoding for the VRAM arbiter.
//               VRAM_BASE / VRAM_END bound the CPU address window that the
//               arbiter's mem_busy applies to. The arbiter state machine
//               uses the 2-bit encoding below.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_arbiter_pkg;

    localparam logic [15:0] VRAM_BASE = 16'h4000;
    localparam logic [15:0] VRAM_END  = 16'h5fff;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t c_ST_IDLE       = 2'd0;
    localparam arb_state_t c_ST_DISP_ISSUE = 2'd1;
    localparam arb_state_t c_ST_DISP_DATA  = 2'd2;
    localparam arb_state_t c_ST_GAP        = 2'd3;

    // True when a CPU byte address falls inside the VRAM window.
    function automatic logic in_vram_window(input logic [15:0] cpu_byte_addr);
        return (cpu_byte_addr >= VRAM_BASE) && (cpu_byte_addr <= VRAM_END);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares the single-port VRAM (1-cycle registered read) between
//               the CPU and the display scanout engine. The display has strict
//               priority; after each display access the CPU owns the RAM for at
//               least CPU_GAP cycles.
// Ports       : clk, reset (async, active-low)
//               cpu_en/cpu_we/cpu_addr/cpu_wdata -> CPU request
//               cpu_rdata                        <- last CPU read result
//               mem_busy                         <- CPU must not access VRAM
//               disp_req/disp_addr               -> display fetch request
//               disp_rdata/disp_valid            <- display fetch result
//               disp_overrun                     <- sticky request overrun
//               ram_addr/ram_we/ram_wdata        -> VRAM macro
//               ram_rdata                        <- VRAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int CPU_GAP = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_busy,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_valid,
    output logic              disp_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int c_CNT_W = (CPU_GAP < 2) ? 1 : $clog2(CPU_GAP + 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(CPU_GAP);
    localparam logic [c_CNT_W-1:0] c_GAP_ONE  = c_CNT_W'(1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [c_CNT_W-1:0]  r_gap_cnt;
    logic                r_pend_v;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [ADDR_W-1:0]   r_issue_addr;
    logic                r_mem_busy;
    logic                r_cpu_inflight;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_disp_rdata;
    logic                r_disp_valid;
    logic                r_disp_overrun;
    logic                w_enter_issue;
    logic                w_cpu_acc;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:       if (r_pend_v || disp_req) w_next_state = c_ST_DISP_ISSUE;
            c_ST_DISP_ISSUE: w_next_state = c_ST_DISP_DATA;
            c_ST_DISP_DATA:  w_next_state = c_ST_GAP;
            c_ST_GAP:        if (r_gap_cnt <= c_GAP_ONE) w_next_state = c_ST_IDLE;
            default:         w_next_state = c_ST_IDLE;
        endcase
    end

    assign w_enter_issue = (r_state == c_ST_IDLE) && (r_pend_v || disp_req);

    // mem_busy is registered, so a low value guarantees the arbiter is not in
    // a display state this cycle and the CPU can drive the RAM directly.
    assign w_cpu_acc = cpu_en && !r_mem_busy;

    // ------------------------------------------------------------------------
    // RAM port mux
    // ------------------------------------------------------------------------
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (r_state == c_ST_DISP_ISSUE) begin
            ram_addr = r_issue_addr;
        end else if (w_cpu_acc) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // State machine, GAP counter and pending slot
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_ST_IDLE;
            r_gap_cnt      <= '0;
            r_mem_busy     <= 1'b0;
            r_pend_v       <= 1'b0;
            r_pend_addr    <= '0;
            r_issue_addr   <= '0;
            r_disp_overrun <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_mem_busy <= (w_next_state == c_ST_DISP_ISSUE) ||
                          (w_next_state == c_ST_DISP_DATA);

            if (r_state == c_ST_DISP_DATA) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if (r_state == c_ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
            end

            // The address being issued is latched separately so that a request
            // arriving in the same cycle the slot drains can refill the slot.
            if (w_enter_issue) begin
                r_issue_addr <= r_pend_v ? r_pend_addr : disp_addr;
                r_pend_v     <= r_pend_v && disp_req;
                if (r_pend_v && disp_req) begin
                    r_pend_addr <= disp_addr;
                end
            end else if (disp_req) begin
                if (r_pend_v) begin
                    r_disp_overrun <= 1'b1;
                end else begin
                    r_pend_v    <= 1'b1;
                    r_pend_addr <= disp_addr;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read data return paths
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_inflight <= 1'b0;
            r_cpu_rdata    <= '0;
            r_disp_rdata   <= '0;
            r_disp_valid   <= 1'b0;
        end else begin
            // CPU read data returns one cycle after acceptance regardless of
            // what the state machine has moved on to.
            r_cpu_inflight <= w_cpu_acc && !cpu_we;
            if (r_cpu_inflight) begin
                r_cpu_rdata <= ram_rdata;
            end

            r_disp_valid <= (r_state == c_ST_DISP_DATA);
            if (r_state == c_ST_DISP_DATA) begin
                r_disp_rdata <= ram_rdata;
            end
        end
    end

    assign mem_busy     = r_mem_busy;
    assign cpu_rdata    = r_cpu_rdata;
    assign disp_rdata   = r_disp_rdata;
    assign disp_valid   = r_disp_valid;
    assign disp_overrun = r_disp_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter with a
//               behavioural 1-cycle registered-read VRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 16;
    localparam int CPU_GAP = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_en;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_busy;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_valid;
    logic              disp_overrun;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    vram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CPU_GAP (CPU_GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_en       (cpu_en),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .mem_busy     (mem_busy),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_rdata   (disp_rdata),
        .disp_valid   (disp_valid),
        .disp_overrun (disp_overrun),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // VRAM model: synchronous write, registered read (old data on collision).
    logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) vram[ram_addr] <= ram_wdata;
        ram_rdata <= vram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        #1;
        chk("cpu_write_we", {31'd0, ram_we}, 32'd1);
        tick();
        cpu_en = 1'b0; cpu_we = 1'b0;
    endtask

    int max_busy, min_low, busy_run, low_run, n_valid, n_bursts;
    logic seen_busy, prev_busy;

    initial begin
        reset = 1'b0; cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        disp_req = 1'b0; disp_addr = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy",     {31'd0, mem_busy},     32'd0);
        chk("rst_valid",    {31'd0, disp_valid},   32'd0);
        chk("rst_overrun",  {31'd0, disp_overrun}, 32'd0);
        chk("rst_cpu_rd",   {16'd0, cpu_rdata},    32'd0);
        chk("rst_ram_we",   {31'd0, ram_we},       32'd0);
        reset = 1'b1;
        tick();
        chk("idle_busy",    {31'd0, mem_busy},     32'd0);

        // Preload through the CPU port
        cpu_write(13'd5,     16'hBEEF);
        cpu_write(13'h100,   16'h1234);
        cpu_write(13'd7,     16'h0007);

        // CPU read of addr 5: accepted at c, data from c+2
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd5;
        tick();
        cpu_en = 1'b0;
        chk("cpu_rd_c1_hold", {16'd0, cpu_rdata}, 32'd0);
        tick();
        chk("cpu_rd_c2", {16'd0, cpu_rdata}, 32'h0000BEEF);

        // Single display fetch
        disp_req = 1'b1; disp_addr = 13'h100;
        chk("disp_t0_busy", {31'd0, mem_busy}, 32'd0);
        tick();
        disp_req = 1'b0;
        chk("disp_t1_busy", {31'd0, mem_busy}, 32'd1);
        chk("disp_t1_addr", {19'd0, ram_addr}, 32'h100);
        chk("disp_t1_we",   {31'd0, ram_we},   32'd0);
        tick();
        chk("disp_t2_busy",  {31'd0, mem_busy},   32'd1);
        chk("disp_t2_valid", {31'd0, disp_valid}, 32'd0);
        tick();
        chk("disp_t3_valid", {31'd0, disp_valid}, 32'd1);
        chk("disp_t3_data",  {16'd0, disp_rdata}, 32'h1234);
        chk("disp_t3_busy",  {31'd0, mem_busy},   32'd0);
        tick();
        chk("disp_t4_valid", {31'd0, disp_valid}, 32'd0);
        chk("disp_no_ovr",   {31'd0, disp_overrun}, 32'd0);
        repeat (3) tick();

        // Collision: CPU read of addr 7 and display request in the same cycle
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 13'd7;
        disp_req = 1'b1; disp_addr = 13'h100;
        tick();
        cpu_en = 1'b0; disp_req = 1'b0;
        chk("col_t1_busy", {31'd0, mem_busy}, 32'd1);
        tick();
        chk("col_t2_cpu",  {16'd0, cpu_rdata}, 32'h0007);
        tick();
        chk("col_t3_valid", {31'd0, disp_valid}, 32'd1);
        chk("col_t3_data",  {16'd0, disp_rdata}, 32'h1234);
        chk("col_t3_cpu",   {16'd0, cpu_rdata},  32'h0007);
        repeat (4) tick();

        // CPU write attempted while busy must be ignored
        disp_req = 1'b1; disp_addr = 13'h100;
        tick();
        disp_req = 1'b0;
        cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h100; cpu_wdata = 16'hDEAD;
        #1;
        chk("ign_t1_we", {31'd0, ram_we}, 32'd0);
        tick();
        chk("ign_t2_we", {31'd0, ram_we}, 32'd0);
        cpu_en = 1'b0; cpu_we = 1'b0;
        tick();
        chk("ign_t3_data", {16'd0, disp_rdata}, 32'h1234);
        repeat (3) tick();
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h100;
        tick();
        cpu_en = 1'b0;
        tick();
        chk("ign_readback", {16'd0, cpu_rdata}, 32'h1234);
        repeat (2) tick();

        // Back-to-back display requests for 10 cycles
        max_busy = 0; min_low = 1000; busy_run = 0; low_run = 0;
        n_valid = 0; n_bursts = 0; seen_busy = 1'b0; prev_busy = 1'b0;
        disp_addr = 13'd5;
        for (int i = 0; i < 25; i++) begin
            disp_req = (i < 10);
            if (disp_valid) n_valid++;
            if (mem_busy) begin
                if (!prev_busy) begin
                    n_bursts++;
                    if (seen_busy && low_run < min_low) min_low = low_run;
                end
                busy_run++;
                if (busy_run > max_busy) max_busy = busy_run;
                low_run = 0;
                seen_busy = 1'b1;
            end else begin
                busy_run = 0;
                if (seen_busy) low_run++;
            end
            prev_busy = mem_busy;
            tick();
        end
        disp_req = 1'b0;
        chk("b2b_max_busy", max_busy, 32'd2);
        chk("b2b_min_low_ge_gap", {31'd0, (min_low >= CPU_GAP)}, 32'd1);
        chk("b2b_bursts",   n_bursts, 32'd3);
        chk("b2b_valids",   n_valid,  32'd3);
        chk("b2b_overrun",  {31'd0, disp_overrun}, 32'd1);
        chk("b2b_last_data", {16'd0, disp_rdata}, 32'h0000BEEF);

        // Async reset asserted in the middle of DISP_DATA
        disp_req = 1'b1; disp_addr = 13'h100;
        tick();
        disp_req = 1'b0;
        tick();
        chk("ar_pre_busy", {31'd0, mem_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_busy",    {31'd0, mem_busy},     32'd0);
        chk("ar_valid",   {31'd0, disp_valid},   32'd0);
        chk("ar_overrun", {31'd0, disp_overrun}, 32'd0);
        chk("ar_disp_rd", {16'd0, disp_rdata},   32'd0);
        chk("ar_cpu_rd",  {16'd0, cpu_rdata},    32'd0);
        chk("ar_ram_we",  {31'd0, ram_we},       32'd0);
        repeat (2) tick();
        reset = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (disp_valid) n_valid++;
        end
        chk("ar_no_valid", n_valid, 32'd0);
        chk("ar_idle_busy", {31'd0, mem_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
